// File: rtl/pin_pattern_gen_if.sv
// pin_pattern_gen_if: control/pattern bus of the pin pattern generator.
// PIN_PATTERN_BURST_EN adds burst_len and done.
interface pin_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int LED_W = 4
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] data;
    logic             data_oe;
    logic             testpin;
    logic             tick;
    logic             busy;
    logic [LED_W-1:0] led;
`ifdef PIN_PATTERN_BURST_EN
    logic [15:0]      burst_len;
    logic             done;
`endif
    modport master (
        output start, stop, mode, seed,
`ifdef PIN_PATTERN_BURST_EN
        output burst_len, input done,
`endif
        input data, data_oe, testpin, tick, busy, led
    );
    modport slave (
        input start, stop, mode, seed,
`ifdef PIN_PATTERN_BURST_EN
        input burst_len, output done,
`endif
        output data, data_oe, testpin, tick, busy, led
    );
endinterface

// File: rtl/pin_pattern_gen.sv
// pin_pattern_gen: divider-paced pin pattern generator (toggle/walk/count/hold).
// PIN_PATTERN_BURST_EN enables auto-stop after burst_len ticks with a done pulse.
module pin_pattern_gen #(
    parameter int DIV   = 500000,
    parameter int WIDTH = 8,
    parameter int LED_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    pin_pattern_gen_if.slave   bus
);
    localparam int CW = $clog2(DIV);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_data;
    logic             data_oe_q;
    logic             testpin_q;
    logic             led0_q;
    logic             busy_q;
    logic             tick_w;
`ifdef PIN_PATTERN_BURST_EN
    logic [15:0]      burst_q;
    logic [15:0]      ticks_q;
    logic             done_q;
    logic             last_w;
    assign last_w   = burst_q != 16'd0 && ticks_q == burst_q - 16'd1;
    assign bus.done = done_q;
`endif
    assign tick_w = state == RUN && cnt == CW'(DIV - 1);
    always_comb begin
        step_data = mode_q == 2'd0 ? ~data_q :
                    mode_q == 2'd1 ? {data_q[WIDTH-2:0], data_q[WIDTH-1]} :
                    mode_q == 2'd2 ? data_q + WIDTH'(1) : data_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 2'd0;
            data_q    <= '0;
            data_oe_q <= 1'b0;
            testpin_q <= 1'b0;
            led0_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PIN_PATTERN_BURST_EN
            burst_q   <= '0;
            ticks_q   <= '0;
            done_q    <= 1'b0;
`endif
        end else begin
`ifdef PIN_PATTERN_BURST_EN
            done_q <= 1'b0;
`endif
            if (state == IDLE) begin
                if (bus.start && !bus.stop) begin
                    state     <= RUN;
                    cnt       <= '0;
                    mode_q    <= bus.mode;
                    data_q    <= (bus.mode == 2'd1 && bus.seed == '0) ? WIDTH'(1) : bus.seed;
                    data_oe_q <= 1'b1;
                    busy_q    <= 1'b1;
`ifdef PIN_PATTERN_BURST_EN
                    burst_q   <= bus.burst_len;
                    ticks_q   <= '0;
`endif
                end
            end else if (bus.stop) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= tick_w ? '0 : cnt + CW'(1);
                if (tick_w) begin
                    data_q    <= step_data;
                    testpin_q <= ~testpin_q;
                    led0_q    <= ~led0_q;
`ifdef PIN_PATTERN_BURST_EN
                    ticks_q   <= ticks_q + 16'd1;
                    if (last_w) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
`endif
                end
            end
        end
    end
    assign bus.data    = data_q;
    assign bus.data_oe = data_oe_q;
    assign bus.testpin = testpin_q;
    assign bus.tick    = tick_w;
    assign bus.busy    = busy_q;
    assign bus.led     = LED_W'({busy_q, led0_q});
endmodule

// File: tb/tb_pin_pattern_gen.sv
// tb_pin_pattern_gen: directed checks of pin_pattern_gen with DIV=4, WIDTH=8, LED_W=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pin_pattern_gen;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    pin_pattern_gen_if #(.WIDTH(8), .LED_W(4)) bus ();
    pin_pattern_gen #(.DIV(4), .WIDTH(8), .LED_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    // Leaves the bench in the first RUN cycle (cnt==0) after the start edge.
    task automatic start_run(input logic [1:0] m, input logic [7:0] s);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.seed  = s;
        wait_n(1);
        bus.start = 1'b0;
    endtask
    task automatic pulse_stop();
        bus.stop = 1'b1;
        wait_n(1);
        bus.stop = 1'b0;
    endtask
    logic [7:0] walk_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 2'd0;
        bus.seed  = 8'h00;
`ifdef PIN_PATTERN_BURST_EN
        bus.burst_len = 16'd0;
`endif
        wait_n(3);
        check("rst_data", bus.data, 8'h00);
        check("rst_oe", bus.data_oe, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_led", bus.led, 4'h0);
        check("rst_testpin", bus.testpin, 1'b0);
        check("rst_tick", bus.tick, 1'b0);
        reset = 1'b1;
        wait_n(2);
        start_run(2'd0, 8'hA5);
        check("tog_seed", bus.data, 8'hA5);
        check("tog_busy", bus.busy, 1'b1);
        check("tog_oe", bus.data_oe, 1'b1);
        check("tog_led0", bus.led, 4'h2);
        check("tog_tick_early", bus.tick, 1'b0);
        wait_n(3);
        check("tog_tick", bus.tick, 1'b1);
        check("tog_data_pre", bus.data, 8'hA5);
        wait_n(1);
        check("tog_step1", bus.data, 8'h5A);
        check("tog_testpin1", bus.testpin, 1'b1);
        check("tog_led1", bus.led, 4'h3);
        check("tog_tick_off", bus.tick, 1'b0);
        bus.start = 1'b1;
        bus.mode  = 2'd2;
        bus.seed  = 8'h00;
        wait_n(1);
        bus.start = 1'b0;
        wait_n(2);
        check("ign_tick", bus.tick, 1'b1);
        wait_n(1);
        check("ign_step2", bus.data, 8'hA5);
        check("ign_testpin", bus.testpin, 1'b0);
        wait_n(4);
        check("tog_step3", bus.data, 8'h5A);
        pulse_stop();
        check("stop_busy", bus.busy, 1'b0);
        check("stop_data", bus.data, 8'h5A);
        check("stop_oe", bus.data_oe, 1'b1);
        check("stop_led", bus.led, 4'h1);
        check("stop_testpin", bus.testpin, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("stop_no_tick", bus.tick, 1'b0);
            wait_n(1);
        end
        check("stop_frozen", bus.data, 8'h5A);
        start_run(2'd1, 8'h00);
        check("walk_seed0", bus.data, 8'h01);
        check("walk_testpin_kept", bus.testpin, 1'b1);
        for (int k = 0; k < 8; k++) begin
            wait_n(4);
            check("walk_step", bus.data, {24'h0, walk_exp[k]});
        end
        check("walk_testpin8", bus.testpin, 1'b1);
        pulse_stop();
        start_run(2'd1, 8'h80);
        check("walk_seed80", bus.data, 8'h80);
        wait_n(4);
        check("walk_wrap", bus.data, 8'h01);
        check("walk_testpin", bus.testpin, 1'b0);
        pulse_stop();
        start_run(2'd2, 8'hFE);
        check("cnt_seed", bus.data, 8'hFE);
        wait_n(4);
        check("cnt_ff", bus.data, 8'hFF);
        wait_n(4);
        check("cnt_wrap", bus.data, 8'h00);
        wait_n(4);
        check("cnt_01", bus.data, 8'h01);
        wait_n(3);
        check("cnt_tick", bus.tick, 1'b1);
        pulse_stop();
        check("tickstop_data", bus.data, 8'h01);
        check("tickstop_busy", bus.busy, 1'b0);
        check("tickstop_testpin", bus.testpin, 1'b1);
        check("tickstop_led", bus.led, 4'h1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.mode  = 2'd0;
        bus.seed  = 8'h33;
        wait_n(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("both_busy", bus.busy, 1'b0);
        check("both_data", bus.data, 8'h01);
        wait_n(4);
        check("both_tick", bus.tick, 1'b0);
        check("both_data_late", bus.data, 8'h01);
        start_run(2'd0, 8'h0F);
        wait_n(2);
        #2 reset = 1'b0;
        #1;
        check("arst_data", bus.data, 8'h00);
        check("arst_oe", bus.data_oe, 1'b0);
        check("arst_testpin", bus.testpin, 1'b0);
        check("arst_led", bus.led, 4'h0);
        check("arst_busy", bus.busy, 1'b0);
        wait_n(2);
        reset = 1'b1;
        wait_n(5);
        check("arst_idle_busy", bus.busy, 1'b0);
        check("arst_idle_tick", bus.tick, 1'b0);
`ifdef PIN_PATTERN_BURST_EN
        bus.burst_len = 16'd3;
        start_run(2'd2, 8'h00);
        check("burst_seed", bus.data, 8'h00);
        wait_n(4);
        check("burst_1", bus.data, 8'h01);
        check("burst_done_early", bus.done, 1'b0);
        wait_n(4);
        check("burst_2", bus.data, 8'h02);
        wait_n(3);
        check("burst_tick3", bus.tick, 1'b1);
        wait_n(1);
        check("burst_3", bus.data, 8'h03);
        check("burst_busy", bus.busy, 1'b0);
        check("burst_done", bus.done, 1'b1);
        wait_n(1);
        check("burst_done_off", bus.done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("burst_no_tick", bus.tick, 1'b0);
            wait_n(1);
        end
        check("burst_hold", bus.data, 8'h03);
        bus.burst_len = 16'd0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
